// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit: fetches through a req/ack handshake, decodes, and sequences the ALU, memory and writeback.
// Optional feature macro: ILLEGAL_TRAP_EN (illegal opcodes trap to 1111 instead of acting as a NOP).
module multicycle_control_fsm #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] instr_in,
  input  logic            instr_ack,
  input  logic            mem_ack,
  output logic            instr_req,
  output logic [3:0]      estado,
  output logic            alusrc,
  output logic [3:0]      alucontrol,
  output logic [11:0]     immediate,
  output logic            negativo,
  output logic            branch,
  output logic            irwrite,
  output logic            memread,
  output logic            memwrite,
  output logic            regwrite,
  output logic            memtoreg,
  output logic            pcwrite,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic            illegal
);

  typedef enum logic [3:0] {
    RESET_ST = 4'b0000,
    FETCH    = 4'b0001,
    DECODE   = 4'b0010,
    EXEC1    = 4'b0101,
    EXEC2    = 4'b0110,
    MEM      = 4'b0111,
    WB       = 4'b1000,
    PC_UPD   = 4'b1001,
    TRAP     = 4'b1111
  } state_t;

  localparam int unsigned CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  state_t          state, state_next;
  logic [XLEN-1:0] ir;
  logic [CW-1:0]   wait_cnt;
  logic            timeout_hit;
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [11:0]     raw_imm;
  logic            is_lw, is_sw, dec_illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RESET_ST;
    else       state <= state_next;
  end

  // All decoded fields come straight from the IR, so they are valid from DECODE until the next fetch lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir       <= '0;
      wait_cnt <= '0;
    end else begin
      if (state == FETCH && instr_ack) ir <= instr_in;
      if (state == MEM) wait_cnt <= wait_cnt + CW'(1);
      else              wait_cnt <= '0;
    end
  end

  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == CW'(MEM_TIMEOUT - 1));

  assign opcode = ir[6:0];
  assign funct3 = ir[14:12];
  assign funct7 = ir[31:25];
  assign rd     = ir[11:7];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];

  always_comb begin
    alucontrol  = '0;
    alusrc      = 1'b0;
    raw_imm     = '0;
    branch      = 1'b0;
    is_lw       = 1'b0;
    is_sw       = 1'b0;
    dec_illegal = 1'b0;
    case (opcode)
      7'b0110011: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000:  alucontrol = 4'b0010;
            3'b111:  alucontrol = 4'b0000;
            3'b110:  alucontrol = 4'b0001;
            3'b100:  alucontrol = 4'b0100;
            3'b101:  alucontrol = 4'b0101;
            default: dec_illegal = 1'b1;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          alucontrol = 4'b0110;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      7'b0010011: begin
        if (funct3 == 3'b000) begin
          alucontrol = 4'b0011;
          alusrc     = 1'b1;
          raw_imm    = ir[31:20];
        end else dec_illegal = 1'b1;
      end
      7'b0000011: begin
        if (funct3 == 3'b010) begin
          alucontrol = 4'b0010;
          alusrc     = 1'b1;
          raw_imm    = ir[31:20];
          is_lw      = 1'b1;
        end else dec_illegal = 1'b1;
      end
      7'b0100011: begin
        if (funct3 == 3'b010) begin
          alucontrol = 4'b0010;
          alusrc     = 1'b1;
          raw_imm    = {ir[31:25], ir[11:7]};
          is_sw      = 1'b1;
        end else dec_illegal = 1'b1;
      end
      7'b1100011: begin
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          alucontrol = (funct3 == 3'b000) ? 4'b0110 : 4'b1111;
          alusrc     = 1'b1;
          raw_imm    = {ir[31], ir[7], ir[30:25], ir[11:8]};
          branch     = 1'b1;
        end else dec_illegal = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign negativo  = raw_imm[11];
  assign immediate = negativo ? (~raw_imm + 12'd1) : raw_imm;

  always_comb begin
    state_next = state;
    instr_req  = 1'b0;
    irwrite    = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    regwrite   = 1'b0;
    memtoreg   = 1'b0;
    pcwrite    = 1'b0;
    case (state)
      RESET_ST: state_next = FETCH;
      FETCH: begin
        instr_req = 1'b1;
        if (instr_ack) begin
          irwrite    = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
`ifdef ILLEGAL_TRAP_EN
        state_next = dec_illegal ? TRAP : EXEC1;
`else
        state_next = dec_illegal ? PC_UPD : EXEC1;
`endif
      end
      EXEC1: state_next = EXEC2;
      EXEC2: begin
        if (is_lw || is_sw) state_next = MEM;
        else if (branch)    state_next = PC_UPD;
        else                state_next = WB;
      end
      MEM: begin
        memread  = is_lw;
        memwrite = is_sw;
        if (mem_ack)          state_next = is_lw ? WB : PC_UPD;
        else if (timeout_hit) state_next = PC_UPD;
      end
      WB: begin
        regwrite   = 1'b1;
        memtoreg   = is_lw;
        state_next = PC_UPD;
      end
      PC_UPD: begin
        pcwrite    = 1'b1;
        state_next = FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP: state_next = TRAP;
`endif
      default: state_next = RESET_ST;
    endcase
  end

  assign estado = state;

`ifdef ILLEGAL_TRAP_EN
  assign illegal = (state == TRAP);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized self-checking bench for multicycle_control_fsm against a transaction-level model of the state walk.
module tb_multicycle_control_fsm;

  localparam int unsigned TO = 4;
  localparam logic [3:0] S_RST = 4'b0000, S_FETCH = 4'b0001, S_DEC = 4'b0010, S_EX1 = 4'b0101,
                         S_EX2 = 4'b0110, S_MEM = 4'b0111, S_WB = 4'b1000, S_PC = 4'b1001, S_TRAP = 4'b1111;
  localparam int K_R = 0, K_ADDI = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_ILL = 5;

  logic        clk = 1'b0, reset = 1'b1;
  logic [31:0] instr_in = '0;
  logic        instr_ack = 1'b0, mem_ack = 1'b0;
  logic        instr_req, alusrc, negativo, branch, irwrite, memread, memwrite;
  logic        regwrite, memtoreg, pcwrite, illegal;
  logic [3:0]  estado, alucontrol;
  logic [11:0] immediate;
  logic [4:0]  rd, rs1, rs2;

  int checks = 0;
  int errors = 0;

  logic [3:0] st_q[$];
  bit         ia_q[$];
  bit         ma_q[$];

  always #5 clk = ~clk;

  multicycle_control_fsm #(.XLEN(32), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .instr_ack(instr_ack), .mem_ack(mem_ack),
    .instr_req(instr_req), .estado(estado), .alusrc(alusrc), .alucontrol(alucontrol),
    .immediate(immediate), .negativo(negativo), .branch(branch), .irwrite(irwrite),
    .memread(memread), .memwrite(memwrite), .regwrite(regwrite), .memtoreg(memtoreg),
    .pcwrite(pcwrite), .rd(rd), .rs1(rs1), .rs2(rs2), .illegal(illegal)
  );

  function automatic logic [45:0] all_outs();
    return {instr_req, estado, alusrc, alucontrol, immediate, negativo, branch, irwrite,
            memread, memwrite, regwrite, memtoreg, pcwrite, rd, rs1, rs2, illegal};
  endfunction

  // Reference decode taken from the opcode tables and immediate formats.
  function automatic void ref_decode(input logic [31:0] i, output int kind, output logic [3:0] alu,
                                     output logic asrc, output logic [11:0] raw, output logic br);
    logic [6:0] op, f7;
    logic [2:0] f3;
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    kind = K_ILL; alu = '0; asrc = 1'b0; raw = '0; br = 1'b0;
    if (op == 7'b0110011) begin
      if (f7 == 7'h00 && f3 == 3'b000)      begin kind = K_R; alu = 4'b0010; end
      else if (f7 == 7'h20 && f3 == 3'b000) begin kind = K_R; alu = 4'b0110; end
      else if (f7 == 7'h00 && f3 == 3'b111) begin kind = K_R; alu = 4'b0000; end
      else if (f7 == 7'h00 && f3 == 3'b110) begin kind = K_R; alu = 4'b0001; end
      else if (f7 == 7'h00 && f3 == 3'b100) begin kind = K_R; alu = 4'b0100; end
      else if (f7 == 7'h00 && f3 == 3'b101) begin kind = K_R; alu = 4'b0101; end
    end else if (op == 7'b0010011 && f3 == 3'b000) begin
      kind = K_ADDI; alu = 4'b0011; asrc = 1'b1; raw = i[31:20];
    end else if (op == 7'b0000011 && f3 == 3'b010) begin
      kind = K_LW; alu = 4'b0010; asrc = 1'b1; raw = i[31:20];
    end else if (op == 7'b0100011 && f3 == 3'b010) begin
      kind = K_SW; alu = 4'b0010; asrc = 1'b1; raw = {i[31:25], i[11:7]};
    end else if (op == 7'b1100011 && (f3 == 3'b000 || f3 == 3'b001)) begin
      kind = K_BR; alu = (f3 == 3'b000) ? 4'b0110 : 4'b1111; asrc = 1'b1; br = 1'b1;
      raw = {i[31], i[7], i[30:25], i[11:8]};
    end
  endfunction

  task automatic push_st(input logic [3:0] s, input bit ia, input bit ma);
    st_q.push_back(s); ia_q.push_back(ia); ma_q.push_back(ma);
  endtask

  // Runs one instruction starting in FETCH; instruction ack after fwait idle cycles, memory ack after mwait.
  task automatic run_instr(input logic [31:0] ins, input int fwait, input int mwait);
    int kind, sv, mag, n;
    logic [3:0] alu, s;
    logic asrc, br, eneg;
    logic [11:0] raw, emag;
    logic [7:0] exp_str, got_str;
    ref_decode(ins, kind, alu, asrc, raw, br);
    sv   = (raw >= 12'd2048) ? int'(raw) - 4096 : int'(raw);
    mag  = (sv < 0) ? -sv : sv;
    emag = 12'(mag);
    eneg = (sv < 0);
    st_q.delete(); ia_q.delete(); ma_q.delete();
    for (int i = 0; i <= fwait; i++) push_st(S_FETCH, i == fwait, 1'($urandom_range(0, 1)));
    push_st(S_DEC, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    if (kind == K_ILL) begin
`ifdef ILLEGAL_TRAP_EN
      for (int i = 0; i < 3; i++) push_st(S_TRAP, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`else
      push_st(S_PC, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
`endif
    end else begin
      push_st(S_EX1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      push_st(S_EX2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (kind == K_LW || kind == K_SW) begin
        n = (mwait < int'(TO)) ? mwait + 1 : int'(TO);
        for (int j = 0; j < n; j++) push_st(S_MEM, 1'($urandom_range(0, 1)), j == mwait);
        if (kind == K_LW && mwait < int'(TO)) push_st(S_WB, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if (kind != K_BR) begin
        push_st(S_WB, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      push_st(S_PC, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    foreach (st_q[idx]) begin
      @(negedge clk);
      instr_ack = ia_q[idx];
      mem_ack   = ma_q[idx];
      instr_in  = ia_q[idx] ? ins : $urandom();
      #1;
      s = st_q[idx];
      checks++;
      if (estado !== s) begin
        errors++;
        $display("FAIL estado ins=%h cyc=%0d got=%b exp=%b", ins, idx, estado, s);
      end
      exp_str = {s == S_FETCH, s == S_FETCH && ia_q[idx], s == S_MEM && kind == K_LW,
                 s == S_MEM && kind == K_SW, s == S_WB, s == S_WB && kind == K_LW, s == S_PC, s == S_TRAP};
      got_str = {instr_req, irwrite, memread, memwrite, regwrite, memtoreg, pcwrite, illegal};
      checks++;
      if (got_str !== exp_str) begin
        errors++;
        $display("FAIL strobes ins=%h cyc=%0d got=%b exp=%b", ins, idx, got_str, exp_str);
      end
      if (s != S_FETCH && kind != K_ILL) begin
        checks++;
        if ({alucontrol, alusrc, immediate, negativo, branch} !== {alu, asrc, emag, eneg, br}) begin
          errors++;
          $display("FAIL fields ins=%h cyc=%0d got=%h/%b/%h/%b/%b exp=%h/%b/%h/%b/%b", ins, idx,
                   alucontrol, alusrc, immediate, negativo, branch, alu, asrc, emag, eneg, br);
        end
        checks++;
        if (rs1 !== ins[19:15] || ((kind == K_R || kind == K_SW || kind == K_BR) && rs2 !== ins[24:20]) ||
            ((kind == K_R || kind == K_ADDI || kind == K_LW) && rd !== ins[11:7])) begin
          errors++;
          $display("FAIL regs ins=%h got=%0d/%0d/%0d exp=%0d/%0d/%0d", ins, rd, rs1, rs2,
                   ins[11:7], ins[19:15], ins[24:20]);
        end
      end
    end
    instr_ack = 1'b0;
    mem_ack   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; instr_ack = 1'b0; mem_ack = 1'b0;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    checks++;
    if (all_outs() !== '0) begin errors++; $display("FAIL reset_outs got=%h exp=0", all_outs()); end
    @(negedge clk); reset = 1'b0; #1;
    checks++;
    if (estado !== S_RST || all_outs() !== '0) begin
      errors++; $display("FAIL reset_release got=%h exp=0", all_outs());
    end
  endtask

  task automatic test_add();
    run_instr(32'h002081B3, 2, 0);
    checks++;
    if ({alucontrol, alusrc, rd} !== {4'b0010, 1'b0, 5'd3}) begin
      errors++; $display("FAIL add_decode got=%h/%b/%0d exp=2/0/3", alucontrol, alusrc, rd);
    end
  endtask

  task automatic test_addi_neg();
    run_instr(32'hFFB00093, 1, 0);
    checks++;
    if ({alucontrol, alusrc, immediate, negativo} !== {4'b0011, 1'b1, 12'h005, 1'b1}) begin
      errors++; $display("FAIL addi_imm got=%h/%b/%h/%b exp=3/1/005/1", alucontrol, alusrc, immediate, negativo);
    end
  endtask

  task automatic test_lw();
    run_instr(32'h00812283, 0, 3);
    checks++;
    if ({immediate, negativo, rd} !== {12'h008, 1'b0, 5'd5}) begin
      errors++; $display("FAIL lw_imm got=%h/%b/%0d exp=008/0/5", immediate, negativo, rd);
    end
  endtask

  task automatic test_branch();
    run_instr(32'h80208063, 0, 0);
    checks++;
    if ({alucontrol, immediate, negativo, branch} !== {4'b0110, 12'h800, 1'b1, 1'b1}) begin
      errors++; $display("FAIL beq_imm got=%h/%h/%b/%b exp=6/800/1/1", alucontrol, immediate, negativo, branch);
    end
    run_instr(32'h80209063, 1, 0);
    checks++;
    if (alucontrol !== 4'b1111) begin errors++; $display("FAIL bne_alu got=%h exp=f", alucontrol); end
  endtask

  task automatic test_illegal();
    run_instr(32'hFFFFFFFF, 0, 0);
`ifdef ILLEGAL_TRAP_EN
    checks++;
    if (illegal !== 1'b1 || estado !== S_TRAP) begin
      errors++; $display("FAIL trap_hold got=%b/%b exp=1/1111", illegal, estado);
    end
    do_reset();
    checks++;
    if (illegal !== 1'b0) begin errors++; $display("FAIL trap_clear got=%b exp=0", illegal); end
`else
    checks++;
    if (illegal !== 1'b0 || pcwrite !== 1'b1) begin
      errors++; $display("FAIL illegal_nop got=%b/%b exp=0/1", illegal, pcwrite);
    end
`endif
  endtask

  task automatic test_timeout();
    run_instr({7'd0, 5'd3, 5'd4, 3'b010, 5'd12, 7'b0100011}, 0, 1000);
    run_instr({12'h7FF, 5'd6, 3'b010, 5'd9, 7'b0000011}, 0, 1000);
  endtask

  task automatic test_reset_mid_mem();
    bit reached = 1'b0;
    @(negedge clk);
    instr_ack = 1'b1;
    instr_in  = {7'd0, 5'd3, 5'd4, 3'b010, 5'd12, 7'b0100011};
    for (int i = 0; i < 10 && !reached; i++) begin
      @(negedge clk); instr_ack = 1'b0; #1;
      if (estado === S_MEM) reached = 1'b1;
    end
    checks++;
    if (!reached || memwrite !== 1'b1) begin
      errors++; $display("FAIL reach_mem got=%b/%b exp=0111/1", estado, memwrite);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (all_outs() !== '0) begin errors++; $display("FAIL reset_in_mem got=%h exp=0", all_outs()); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_random(input int n, input int maxf, input int maxm);
    logic [31:0] ins;
    logic [11:0] imm;
    logic [4:0] a, b, c;
    logic [6:0] r_f7[6];
    logic [2:0] r_f3[6];
    int kind, sel;
    r_f7 = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00};
    r_f3 = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b100, 3'b101};
    for (int k = 0; k < n; k++) begin
`ifdef ILLEGAL_TRAP_EN
      kind = $urandom_range(0, 4);
`else
      kind = $urandom_range(0, 5);
`endif
      a = 5'($urandom); b = 5'($urandom); c = 5'($urandom);
      case ($urandom_range(0, 5))
        0: imm = 12'h800;
        1: imm = 12'h7FF;
        2: imm = 12'hFFF;
        default: imm = 12'($urandom);
      endcase
      sel = $urandom_range(0, 5);
      case (kind)
        K_R:    ins = {r_f7[sel], b, a, r_f3[sel], c, 7'b0110011};
        K_ADDI: ins = {imm, a, 3'b000, c, 7'b0010011};
        K_LW:   ins = {imm, a, 3'b010, c, 7'b0000011};
        K_SW:   ins = {imm[11:5], b, a, 3'b010, imm[4:0], 7'b0100011};
        K_BR:   ins = {imm[11], imm[9:4], b, a, 2'b00, sel[0], imm[3:0], imm[10], 7'b1100011};
        default: begin
          case (sel % 4)
            0: ins = 32'hFFFFFFFF;
            1: ins = {7'b0000001, b, a, 3'b000, c, 7'b0110011};
            2: ins = {imm, a, 3'b001, c, 7'b0010011};
            default: ins = {imm, a, 3'b000, c, 7'b0000011};
          endcase
        end
      endcase
      run_instr(ins, $urandom_range(0, maxf), $urandom_range(0, maxm));
    end
  endtask

  task automatic test_back_to_back();
    test_random(8, 0, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_addi_neg();
    test_lw();
    test_branch();
    test_illegal();
    test_timeout();
    test_reset_mid_mem();
    test_back_to_back();
    test_random(40, 3, 6);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
